// File: rtl/fp_pkg.sv
// Shared definitions for the normalize/pack controller: FSM states,
// flag bit positions and exponent limits.
package fp_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DETECT = 2'd1,
        S_SHIFT  = 2'd2,
        S_PACK   = 2'd3
    } state_t;

    // out_flags = {zero, overflow, underflow}
    localparam int FLAG_ZERO = 2;
    localparam int FLAG_OVF  = 1;
    localparam int FLAG_UNF  = 0;

    localparam logic [7:0] EXP_MAX = 8'hFF;

endpackage

// File: rtl/find1.sv
// 25-bit leading-one detector: counts zeros above the first 1 in d[23:0]
// (bit23 downward) and flags an all-zero input.
module find1 (
    input  logic [24:0] d,
    output logic [4:0]  cnt,
    output logic        zero
);

    always_comb begin
        cnt = '0;
        // Ascending scan: the last hit is the highest set bit.
        for (int i = 0; i < 24; i++) begin
            if (d[i]) cnt = 5'(23 - i);
        end
        zero = ~|d;
    end

endmodule

// File: rtl/fp_norm_ctrl.sv
// Multi-cycle normalizer: takes an unnormalized sign/exp/mantissa, shifts it
// into place and packs an IEEE-754 single (truncating, flush-to-zero).
module fp_norm_ctrl
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [24:0] in_mant,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_fp,
    output logic [2:0]  out_flags,
    output logic        busy
);

    state_t      state, state_nxt;
    logic        op_sign;
    logic [7:0]  op_exp;
    logic [24:0] op_mant;
    logic [4:0]  lz_r, lz_w;
    logic        zero_r, zero_w;
    logic [31:0] res_fp;
    logic [2:0]  res_flags;
    logic [8:0]  e9, e_new;
    logic [23:0] m_shl;

    find1 u_find1 (
        .d    (op_mant),
        .cnt  (lz_w),
        .zero (zero_w)
    );

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_PACK);
    assign busy      = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (in_valid && in_ready) state_nxt = S_DETECT;
            S_DETECT: state_nxt = S_SHIFT;
            S_SHIFT:  state_nxt = S_PACK;
            S_PACK:   if (out_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Exponent math is 9 bits so carry-increment and lz compare never wrap.
    always_comb begin
        e9        = {1'b0, op_exp};
        e_new     = '0;
        m_shl     = op_mant[23:0] << lz_r;
        res_fp    = '0;
        res_flags = '0;
        if (zero_r) begin
            res_fp              = {op_sign, 31'b0};
            res_flags[FLAG_ZERO] = 1'b1;
        end else if (op_exp == EXP_MAX || (op_mant[24] && (e9 + 9'd1) >= 9'd255)) begin
            res_fp              = {op_sign, EXP_MAX, 23'b0};
            res_flags[FLAG_OVF] = 1'b1;
        end else if (op_mant[24]) begin
            e_new  = e9 + 9'd1;
            res_fp = {op_sign, e_new[7:0], op_mant[23:1]};
        end else if (e9 > {4'b0, lz_r}) begin
            e_new  = e9 - {4'b0, lz_r};
            res_fp = {op_sign, e_new[7:0], m_shl[22:0]};
        end else begin
            res_fp              = {op_sign, 31'b0};
            res_flags[FLAG_UNF] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_sign   <= 1'b0;
            op_exp    <= '0;
            op_mant   <= '0;
            lz_r      <= '0;
            zero_r    <= 1'b0;
            out_fp    <= '0;
            out_flags <= '0;
        end else begin
            state <= state_nxt;
            if (in_valid && in_ready) begin
                op_sign <= in_sign;
                op_exp  <= in_exp;
                op_mant <= in_mant;
            end
            if (state == S_DETECT) begin
                lz_r   <= lz_w;
                zero_r <= zero_w;
            end
            // Result is captured only on the SHIFT->PACK edge, so it stays put while stalled.
            if (state == S_SHIFT) begin
                out_fp    <= res_fp;
                out_flags <= res_flags;
            end
        end
    end

endmodule

// File: tb/tb_fp_norm_ctrl.sv
// Bench for fp_norm_ctrl: directed corner cases, stall/reset scenarios and
// randomized operands against an arithmetic reference model.
module tb_fp_norm_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_fp;
    logic [2:0]  out_flags;
    logic        busy;

    int total = 0;
    int bad   = 0;

    localparam longint TWO23 = 64'd8388608;
    localparam longint TWO24 = 64'd16777216;
    // Accept edge -> out_valid seen after two more edges (accept cycle = 0, PACK = cycle 3).
    localparam int LAT = 2;

    fp_norm_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_fp    (out_fp),
        .out_flags (out_flags),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the value, normalizing by doubling.
    function automatic void ref_model(input logic s, input int e, input longint m,
                                      output logic [31:0] fp, output logic [2:0] fl);
        int     lz;
        longint mm;
        if (m == 0) begin
            fp = {s, 31'b0}; fl = 3'b100;
        end else if (e == 255 || (m >= TWO24 && e + 1 >= 255)) begin
            fp = {s, 8'hFF, 23'b0}; fl = 3'b010;
        end else if (m >= TWO24) begin
            fp = {s, 8'(e + 1), 23'((m / 2) % TWO23)}; fl = 3'b000;
        end else begin
            lz = 0; mm = m;
            while (mm < TWO23) begin mm = mm * 2; lz++; end
            if (e > lz) begin
                fp = {s, 8'(e - lz), 23'(mm % TWO23)}; fl = 3'b000;
            end else begin
                fp = {s, 31'b0}; fl = 3'b001;
            end
        end
    endfunction

    // Drive one operand, wait for the result, optionally stall, then handshake.
    task automatic do_op(input logic s, input logic [7:0] e, input logic [24:0] m, input int stall,
                         output logic [31:0] fp, output logic [2:0] fl, output int lat,
                         output logic stable, output logic rdy_low);
        @(negedge clk);
        in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        fp = out_fp; fl = out_flags; stable = 1'b1; rdy_low = 1'b1;
        repeat (stall) begin
            @(posedge clk); #1;
            if (out_fp !== fp || out_flags !== fl || out_valid !== 1'b1) stable = 1'b0;
            if (in_ready !== 1'b0) rdy_low = 1'b0;
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_sign = 1'b0; in_exp = '0; in_mant = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({in_ready, out_valid, busy, out_fp, out_flags} !== {3'b100, 32'h0, 3'b000}) begin
            bad++;
            $display("FAIL reset: rdy/vld/busy/fp/fl=%b%b%b %h %b want 100 00000000 000",
                     in_ready, out_valid, busy, out_fp, out_flags);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] fp; logic [2:0] fl; int lat; logic st, rl;
        logic        s_t [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0]  e_t [5] = '{8'h80, 8'h7F, 8'h7F, 8'h42, 8'hFE};
        logic [24:0] m_t [5] = '{25'h0800000, 25'h1000000, 25'h0000001, 25'h0, 25'h1800000};
        logic [31:0] f_t [5] = '{32'h40000000, 32'h40000000, 32'h34000000, 32'h80000000, 32'h7F800000};
        logic [2:0]  g_t [5] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b010};
        for (int i = 0; i < 5; i++) begin
            do_op(s_t[i], e_t[i], m_t[i], 0, fp, fl, lat, st, rl);
            total++;
            if (fp !== f_t[i] || fl !== g_t[i] || lat !== LAT) begin
                bad++;
                $display("FAIL directed%0d: fp=%h fl=%b lat=%0d want fp=%h fl=%b lat=%0d",
                         i, fp, fl, lat, f_t[i], g_t[i], LAT);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] fp; logic [2:0] fl; int lat; logic st, rl;
        do_op(1'b0, 8'h05, 25'h0000100, 4, fp, fl, lat, st, rl);
        total++;
        if (fp !== 32'h0 || fl !== 3'b001 || st !== 1'b1 || rl !== 1'b1) begin
            bad++;
            $display("FAIL stall: fp=%h fl=%b stable=%b rdy_low=%b want 00000000 001 1 1", fp, fl, st, rl);
        end
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] fp; logic [2:0] fl; int lat; logic st, rl; logic seen;
        @(negedge clk);
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'h80; in_mant = 25'h0800000;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1;           // now in SHIFT
        rst_n = 1'b0; #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_fp !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid: in_ready=%b out_valid=%b busy=%b fp=%h want 1 0 0 00000000",
                     in_ready, out_valid, busy, out_fp);
        end
        seen = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        rst_n = 1'b1;                  // next negedge presents; first edge after release accepts
        do_op(1'b1, 8'h10, 25'h0400000, 0, fp, fl, lat, st, rl);
        total++;
        if (seen || fp !== 32'h87800000 || fl !== 3'b000 || lat !== LAT) begin
            bad++;
            $display("FAIL reset_recover: ghost=%b fp=%h fl=%b lat=%0d want 0 87800000 000 %0d",
                     seen, fp, fl, lat, LAT);
        end
    endtask

    task automatic test_busy_ignore();
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'h7F; in_mant = 25'h0C00000;
        @(posedge clk); #1;
        in_exp = 8'h01; in_mant = 25'h0;   // keep in_valid high with a different operand
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        total++;
        if (out_fp !== 32'h3FC00000 || out_flags !== 3'b000 || busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_ignore: fp=%h fl=%b busy=%b want 3fc00000 000 1", out_fp, out_flags, busy);
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] fp, efp; logic [2:0] fl, efl; int lat; logic st, rl;
        logic s; logic [7:0] e; logic [24:0] m; int mode;
        for (int i = 0; i < 60; i++) begin
            s = 1'($urandom);
            mode = $urandom_range(0, 5);
            case (mode)
                0: m = '0;
                1: m = 25'h1000000 | 25'($urandom);
                default: m = 25'($urandom) >> $urandom_range(1, 24);
            endcase
            case ($urandom_range(0, 3))
                0: e = 8'($urandom_range(0, 24));
                1: e = 8'($urandom_range(250, 255));
                default: e = 8'($urandom);
            endcase
            ref_model(s, int'(e), longint'(m), efp, efl);
            do_op(s, e, m, i % 3, fp, fl, lat, st, rl);
            total++;
            if (fp !== efp || fl !== efl || lat !== LAT || st !== 1'b1) begin
                bad++;
                $display("FAIL random%0d: in=%b/%h/%h fp=%h fl=%b lat=%0d stable=%b want fp=%h fl=%b lat=%0d",
                         i, s, e, m, fp, fl, lat, st, efp, efl, LAT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_reset_mid();
        test_busy_ignore();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
